// File: rtl/zot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zot_pkg
// Description : Shared encodings for the zot controller and its sequencer:
//               zot state codes, error codes and the driver state type.
// Revision    : 1.0 - initial release
// ============================================================================
package zot_pkg;

    // Controller state as presented on the zot bus
    localparam logic [2:0] ZOT_S0 = 3'b000;
    localparam logic [2:0] ZOT_S1 = 3'b101;
    localparam logic [2:0] ZOT_S2 = 3'b111;
    localparam logic [2:0] ZOT_S3 = 3'b001;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_SEQ     = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    // Driver sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_EXPECT2 = 3'd2,
        ST_HOLD    = 3'd3,
        ST_EXPECT0 = 3'd4
    } drv_state_e;

endpackage
`default_nettype wire

// File: rtl/zot_decode.sv
`default_nettype none
// ============================================================================
// Module      : zot_decode
// Description : Combinational classifier for the zot bus. Flags each legal
//               state code and whether the value is legal at all.
// Revision    : 1.0 - initial release
// ============================================================================
module zot_decode
    import zot_pkg::*;
(
    input  logic [2:0] i_zot,
    output logic       o_legal,
    output logic       o_is_s0,
    output logic       o_is_s1,
    output logic       o_is_s2,
    output logic       o_is_s3
);

    // Match the four legal encodings; anything else is illegal
    always_comb begin
        o_is_s0 = (i_zot == ZOT_S0);
        o_is_s1 = (i_zot == ZOT_S1);
        o_is_s2 = (i_zot == ZOT_S2);
        o_is_s3 = (i_zot == ZOT_S3);
        o_legal = o_is_s0 | o_is_s1 | o_is_s2 | o_is_s3;
    end

endmodule
`default_nettype wire

// File: rtl/zot_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : zot_seq_driver
// Description : Initiator-side sequencer for the zot controller. Accepts a
//               run command, drives start/skip3/wait3, checks the returned
//               zot sequence and reports done or err per run.
// Revision    : 1.0 - initial release
// ============================================================================
module zot_seq_driver
    import zot_pkg::*;
#(
    parameter int WAIT_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_skip,
    input  logic [WAIT_W-1:0] cmd_wait_len,
    output logic              start,
    output logic              skip3,
    output logic              wait3,
    input  logic [2:0]        zot,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       run_count
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    drv_state_e        state_q, state_d;
    logic              skip_q, skip_d;
    logic [WAIT_W-1:0] wait_len_q, wait_len_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       run_count_q, run_count_d;

    logic w_legal, w_is_s0, w_is_s1, w_is_s2, w_is_s3;

    zot_decode u_decode (
        .i_zot   (zot),
        .o_legal (w_legal),
        .o_is_s0 (w_is_s0),
        .o_is_s1 (w_is_s1),
        .o_is_s2 (w_is_s2),
        .o_is_s3 (w_is_s3)
    );

    // State register and status flops; reset aborts any run with no report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            skip_q      <= 1'b0;
            wait_len_q  <= '0;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            run_count_q <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            wait_len_q  <= wait_len_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            run_count_q <= run_count_d;
        end
    end

    // Next-state logic, zot checking and state-decoded controller drives
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        wait_len_d  = wait_len_q;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        run_count_d = run_count_q;

        // Drives depend only on the current state, so any error drops them
        // on the same edge that returns the driver to IDLE.
        cmd_ready = (state_q == ST_IDLE) && !reset;
        busy      = (state_q != ST_IDLE);
        start     = (state_q == ST_LAUNCH);
        skip3     = (state_q == ST_EXPECT2) && skip_q;
        wait3     = (state_q == ST_HOLD) && (cnt_q != '0);

        if (state_q != ST_IDLE && !w_legal) begin
            // An unknown code outranks any sequence check
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        skip_d     = cmd_skip;
                        wait_len_d = cmd_wait_len;
                        to_cnt_d   = '0;
                        state_d    = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (w_is_s1) begin
                        state_d = ST_EXPECT2;
                    end else if (!w_is_s0) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_SEQ;
                    end else if (to_cnt_q == TO_LAST) begin
                        // This is the TIMEOUT-th LAUNCH cycle still at S0
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_EXPECT2: begin
                    if (!w_is_s2) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_SEQ;
                    end else if (skip_q) begin
                        state_d = ST_EXPECT0;
                    end else begin
                        cnt_d   = wait_len_q;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_is_s3) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_SEQ;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = ST_EXPECT0;
                    end
                end
                ST_EXPECT0: begin
                    state_d = ST_IDLE;
                    if (w_is_s0) begin
                        done_d      = 1'b1;
                        run_count_d = run_count_q + 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SEQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign run_count = run_count_q;

endmodule
`default_nettype wire

// File: tb/tb_zot_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_zot_seq_driver
// Description : Self-checking bench for zot_seq_driver paired with a
//               behavioural zot controller, with zot override for faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zot_seq_driver;

    localparam int WAIT_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_skip;
    logic [WAIT_W-1:0] cmd_wait_len;
    logic              start, skip3, wait3;
    logic [2:0]        zot;
    logic              busy, done, err;
    logic [1:0]        err_code;
    logic [15:0]       run_count;

    logic [2:0] ctrl_zot;
    logic       ctrl_hold;
    logic       frc_en;
    logic [2:0] frc_val;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses  = 0;
    int done_pulses = 0;
    logic [15:0] exp_runs;

    typedef struct {
        bit skip;
        int wl;
        int exp_lat;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    assign zot = frc_en ? frc_val : ctrl_zot;

    zot_seq_driver #(.WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_skip     (cmd_skip),
        .cmd_wait_len (cmd_wait_len),
        .start        (start),
        .skip3        (skip3),
        .wait3        (wait3),
        .zot          (zot),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .run_count    (run_count)
    );

    // Behavioural zot controller: S0 -start-> S1 -> S2 -> S0 (skip3) or S3,
    // S3 holds while wait3
    always @(posedge clk or posedge reset) begin
        if (reset || ctrl_hold) ctrl_zot <= 3'b000;
        else begin
            case (ctrl_zot)
                3'b000:  if (start) ctrl_zot <= 3'b101;
                3'b101:  ctrl_zot <= 3'b111;
                3'b111:  ctrl_zot <= skip3 ? 3'b000 : 3'b001;
                3'b001:  ctrl_zot <= wait3 ? 3'b001 : 3'b000;
                default: ctrl_zot <= 3'b000;
            endcase
        end
    end

    // Pulse monitors
    always @(negedge clk) begin
        if (err)  err_pulses++;
        if (done) done_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a command on a negedge; returns just after the accept edge (E1)
    task automatic send_cmd(input bit skip, input int wl);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_skip     = skip;
        cmd_wait_len = wl[WAIT_W-1:0];
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
    endtask

    // Issue a command and observe until done/err, lat = cycle index after E1
    task automatic run_measure(input bit skip, input int wl, output int lat,
                               output int n_start, output int n_wait3, output int n_s3);
        lat = 0; n_start = 0; n_wait3 = 0; n_s3 = 0;
        send_cmd(skip, wl);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (start) n_start++;
            if (wait3) n_wait3++;
            if (zot == 3'b001) n_s3++;
            if (done || err) begin
                lat = k;
                break;
            end
        end
    endtask

    // One successful run compared against the rule-derived expectations
    task automatic do_run(input string name, input bit skip, input int wl, input int exp_lat);
        int lat, ns, nw, n3, errs0;
        errs0 = err_pulses;
        run_measure(skip, wl, lat, ns, nw, n3);
        exp_runs = exp_runs + 16'd1;
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".done"}, done, 1);
        check({name, ".start_cycles"}, ns, 2);
        check({name, ".wait3_cycles"}, nw, skip ? 0 : wl);
        check({name, ".s3_cycles"}, n3, skip ? 0 : wl + 1);
        check({name, ".run_count"}, run_count, exp_runs);
        check({name, ".ready_at_done"}, cmd_ready, 1);
        check({name, ".no_err"}, err_pulses - errs0, 0);
    endtask

    initial begin
        int lat, ns, nw, n3, e0, d0;
        bit rs;
        int rw;

        vecs[0] = '{skip: 1'b1, wl: 0,   exp_lat: 5};
        vecs[1] = '{skip: 1'b0, wl: 3,   exp_lat: 9};
        vecs[2] = '{skip: 1'b0, wl: 0,   exp_lat: 6};
        vecs[3] = '{skip: 1'b0, wl: 1,   exp_lat: 7};
        vecs[4] = '{skip: 1'b1, wl: 200, exp_lat: 5};
        vecs[5] = '{skip: 1'b0, wl: 255, exp_lat: 261};

        reset = 1'b1; cmd_valid = 1'b0; cmd_skip = 1'b0; cmd_wait_len = '0;
        ctrl_hold = 1'b0; frc_en = 1'b0; frc_val = 3'b000;
        exp_runs = 16'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.cmd_ready", cmd_ready, 0);
        check("rst.start", start, 0);
        check("rst.busy", busy, 0);
        check("rst.done_err", {done, err}, 0);
        check("rst.err_code", err_code, 0);
        check("rst.run_count", run_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle.cmd_ready", cmd_ready, 1);

        // Directed table
        foreach (vecs[i]) do_run($sformatf("vec%0d", i), vecs[i].skip, vecs[i].wl, vecs[i].exp_lat);

        // Randomized runs against the rule model
        for (int r = 0; r < 20; r++) begin
            rs = $urandom_range(0, 1);
            rw = $urandom_range(0, 255);
            do_run($sformatf("rnd%0d", r), rs, rw, rs ? 5 : 6 + rw);
        end

        // Timeout: controller parked in S0
        ctrl_hold = 1'b1;
        e0 = err_pulses;
        run_measure(1'b1, 0, lat, ns, nw, n3);
        check("tmo.latency", lat, TIMEOUT + 1);
        check("tmo.err", err, 1);
        check("tmo.err_code", err_code, 1);
        check("tmo.start_cycles", ns, TIMEOUT);
        check("tmo.start_low", start, 0);
        check("tmo.cmd_ready", cmd_ready, 1);
        check("tmo.run_count", run_count, exp_runs);
        ctrl_hold = 1'b0;
        @(negedge clk);
        check("tmo.err_one_pulse", err_pulses - e0, 1);

        // Illegal zot during HOLD
        send_cmd(1'b0, 5);
        repeat (5) @(negedge clk);
        check("ill.in_hold", wait3, 1);
        frc_en = 1'b1; frc_val = 3'b010;
        @(negedge clk);
        check("ill.err", err, 1);
        check("ill.err_code", err_code, 3);
        check("ill.drives_low", {start, skip3, wait3, busy}, 0);
        check("ill.run_count", run_count, exp_runs);
        frc_en = 1'b0;
        repeat (3) @(negedge clk);
        check("ill.code_sticky", err_code, 3);

        // Sequence mismatch during EXPECT2
        send_cmd(1'b1, 0);
        repeat (3) @(negedge clk);
        check("seq.in_expect2", skip3, 1);
        frc_en = 1'b1; frc_val = 3'b001;
        @(negedge clk);
        check("seq.err", err, 1);
        check("seq.err_code", err_code, 2);
        check("seq.drives_low", {start, skip3, wait3}, 0);
        frc_en = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-HOLD
        e0 = err_pulses; d0 = done_pulses;
        send_cmd(1'b0, 10);
        repeat (6) @(negedge clk);
        check("arst.pre_wait3", wait3, 1);
        #2 reset = 1'b1;
        #1;
        check("arst.outputs", {cmd_ready, start, skip3, wait3, busy, done, err}, 0);
        check("arst.run_count", run_count, 0);
        check("arst.err_code", err_code, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_runs = 16'd0;
        repeat (2) @(negedge clk);
        check("arst.no_pulses", (err_pulses - e0) + (done_pulses - d0), 0);
        do_run("arst.after", 1'b1, 0, 5);

        // run_count wrap and back-to-back accept across the done cycle
        @(negedge clk);
        force dut.run_count_q = 16'hFFFF;
        #1 release dut.run_count_q;
        exp_runs = 16'hFFFF;
        @(negedge clk);
        check("wrap.preload", run_count, 16'hFFFF);
        send_cmd(1'b1, 0);
        repeat (4) @(negedge clk);
        cmd_valid = 1'b1; cmd_skip = 1'b1; cmd_wait_len = '0;
        check("b2b.not_ready_expect0", cmd_ready, 0);
        @(negedge clk);
        check("wrap.done", done, 1);
        check("wrap.run_count", run_count, 16'h0000);
        check("b2b.ready_in_done", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) check("b2b.busy", busy, 1);
            if (done || err) begin
                lat = k;
                break;
            end
        end
        check("b2b.latency", lat, 5);
        check("b2b.run_count", run_count, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
